mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Iterative shift-add unsigned multiplier with its own controller, used by the CPU's MUL instruction. The CPU pulses a start, stalls on busy, and writes back the low half of the result when done pulses. The block replaces a combinational multiplier so that MUL fits Spartan-3E timing. It holds one operation at a time and has no queue.

Parameters:
WIDTH, 16, operand width in bits; the product is 2*WIDTH bits wide.
EARLY_EXIT, 0, when 1, RUN ends as soon as no multiplier bits remain.

Ports:
Clock  input  1  system clock; every register updates on the rising edge.
Reset  input  1  synchronous, active-low reset.
iStart  input  1  start request; sampled only in IDLE.
iA  input  WIDTH  multiplicand; latched on an accepted start.
iB  input  WIDTH  multiplier; latched on an accepted start.
oBusy  output  1  high in RUN and DONE.
oDone  output  1  one-cycle pulse; high in DONE.
oResult  output  2*WIDTH  product; holds its value until the next accepted start.
oOverflow  output  1  high when oResult[2*WIDTH-1:WIDTH] != 0; valid together with oResult.

Behaviour:
- Reset, when Reset==0 at an edge:
  - state=IDLE.
  - oBusy=0, oDone=0, oResult=0, oOverflow=0.
  - All internal registers are cleared to 0.
  - This applies in every state, including mid-RUN; the operation in progress is discarded and no oDone is produced.
- Internal registers:
  - mcand, 2*WIDTH bits.
  - mplier, WIDTH bits.
  - acc, 2*WIDTH bits.
  - cnt, clog2(WIDTH) bits.
- IDLE:
  - If iStart==1 at edge k: mcand={0,iA}, mplier=iB, acc=0, cnt=0, go to RUN. oBusy is high from cycle k+1.
  - If iStart==0: stay in IDLE.
  - oResult is not cleared on start; it keeps the previous product until DONE.
- RUN, one multiplier bit per cycle:
  - If mplier[0]==1: acc = acc + mcand, modulo 2^(2*WIDTH). No carry is lost, because the product fits in 2*WIDTH bits.
  - mcand <<= 1, mplier >>= 1, cnt++.
  - Go to DONE when cnt==WIDTH-1, or when EARLY_EXIT==1 and (mplier>>1)==0.
  - Otherwise stay in RUN.
- DONE, one cycle:
  - oDone=1.
  - oResult=acc (registered into DONE, so it is valid in the same cycle as oDone).
  - oOverflow is computed from that acc.
  - Unconditionally return to IDLE.
- Latency, with the start sampled at edge k:
  - EARLY_EXIT=0: RUN occupies cycles k+1..k+WIDTH; oDone is high in cycle k+WIDTH+1 (k+17 for WIDTH=16).
  - EARLY_EXIT=1: RUN lasts max(1, msb_index(iB)+1) cycles, so iB=0 gives oDone at k+2.
- iStart while in RUN or DONE: ignored, not queued, no side effects. A start can be accepted in the cycle right after DONE, giving back-to-back operations with one IDLE cycle between them.
- iA and iB may change after acceptance without effect.
- Operands of 0, or iA=2^WIDTH-1 and iB=2^WIDTH-1: no special cases; the result is exact.
- No X propagation: every state register has a default assignment, and an illegal state code returns to IDLE.

Decomposition:
- State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) goes into the shared definitions header as `defines next to the opcode definitions.
- A `define for the default WIDTH also goes in the header.
- No sub-module: the counter and datapath are small enough to stay inline with the FSM.

Test Plan:
- Reset held low 3 cycles, then released → oBusy=0, oDone=0, oResult=0, oOverflow=0; no oDone for 40 cycles with iStart=0.
- iA=465, iB=70, 1-cycle start at edge k, EARLY_EXIT=0 → oDone pulses only at k+17; oResult=32550 (0x00007F26); oOverflow=0; oBusy high in cycles k+1..k+17.
- Same operands with EARLY_EXIT=1 → oDone at k+8, oResult=32550. Then iB=0 → oDone at k+2, oResult=0.
- iA=0xFFFF, iB=0xFFFF → oResult=0xFFFE0001, oOverflow=1. Next start with 3×5 → oResult=15, oOverflow=0.
- Start 465×70, then iStart=1 with iA=2, iB=2 held high through cycles k+3..k+10 (busy) → a single oDone at k+17 with oResult=32550; a new start is accepted only once the block is back in IDLE.
- Start 465×70, pull Reset low at k+6 for one cycle → oResult=0 and oBusy=0 on the next cycle, no oDone. Next start 7×9 → oResult=63 at the nominal latency.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative shift-add multiplier: default width,
// controller state codes and counter sizing.
package mul_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The bit counter needs at least one bit, even for a 1-bit multiplier.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Iterative shift-add unsigned multiplier with built-in controller: one multiplier
// bit per cycle, one operation in flight, result held until the next accepted start.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult,
    output logic                 oOverflow
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_overflow;

    logic [1:0]           w_state_d;
    logic [2*WIDTH-1:0]   w_mcand_d;
    logic [WIDTH-1:0]     w_mplier_d;
    logic [2*WIDTH-1:0]   w_acc_d;
    logic [CNT_W-1:0]     w_cnt_d;
    logic [2*WIDTH-1:0]   w_result_d;
    logic                 w_overflow_d;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic                 w_last;

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    // Early exit once the bit being consumed is the last set one.
    assign w_last     = (r_cnt == CNT_LAST) || (EARLY_EXIT && ((r_mplier >> 1) == '0));

    always_comb begin
        w_state_d    = r_state;
        w_mcand_d    = r_mcand;
        w_mplier_d   = r_mplier;
        w_acc_d      = r_acc;
        w_cnt_d      = r_cnt;
        w_result_d   = r_result;
        w_overflow_d = r_overflow;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_mcand_d  = {{WIDTH{1'b0}}, iA};
                    w_mplier_d = iB;
                    w_acc_d    = '0;
                    w_cnt_d    = '0;
                    w_state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                w_acc_d    = w_acc_step;
                w_mcand_d  = r_mcand << 1;
                w_mplier_d = r_mplier >> 1;
                w_cnt_d    = r_cnt + 1'b1;
                if (w_last) begin
                    // Load the product on entry to DONE so it lines up with oDone.
                    w_result_d   = w_acc_step;
                    w_overflow_d = |w_acc_step[2*WIDTH-1:WIDTH];
                    w_state_d    = ST_DONE;
                end
            end
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_mcand    <= w_mcand_d;
            r_mplier   <= w_mplier_d;
            r_acc      <= w_acc_d;
            r_cnt      <= w_cnt_d;
            r_result   <= w_result_d;
            r_overflow <= w_overflow_d;
        end
    end

    assign oBusy     = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign oDone     = (r_state == ST_DONE);
    assign oResult   = r_result;
    assign oOverflow = r_overflow;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: two instances (EARLY_EXIT 0 and 1) on shared inputs, each
// compared every cycle against a transaction-level model (product and completion time).
module tb_mul_sequencer;

    localparam int W = 16;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic [W-1:0] iA;
    logic [W-1:0] iB;
    logic        busy [2];
    logic        done [2];
    logic        ovf  [2];
    logic [2*W-1:0] res [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: per instance, whether an op is in flight, the edge it completes on, its product.
    bit     m_active [2];
    bit     m_done   [2];
    bit     m_ovf    [2];
    longint m_res    [2];
    longint m_prod   [2];
    int     m_dcyc   [2];
    int     obs_done [2];
    int     obs_ndone[2];

    mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB),
        .oBusy(busy[0]), .oDone(done[0]), .oResult(res[0]), .oOverflow(ovf[0])
    );

    mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB),
        .oBusy(busy[1]), .oDone(done[1]), .oResult(res[1]), .oOverflow(ovf[1])
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Number of RUN cycles for multiplier b.
    function automatic int run_len(input int ee, input logic [W-1:0] b);
        if (ee == 0) return W;
        for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (!Reset) begin
                m_active[m] = 1'b0;
                m_done[m]   = 1'b0;
                m_res[m]    = 0;
                m_ovf[m]    = 1'b0;
            end else if (m_done[m]) begin
                m_done[m]   = 1'b0;
                m_active[m] = 1'b0;
            end else if (m_active[m]) begin
                if (cyc == m_dcyc[m]) begin
                    m_done[m] = 1'b1;
                    m_res[m]  = m_prod[m];
                    m_ovf[m]  = (m_prod[m] >> W) != 0;
                end
            end else if (iStart) begin
                m_active[m] = 1'b1;
                m_dcyc[m]   = cyc + run_len(m, iB);
                m_prod[m]   = longint'(iA) * longint'(iB);
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("busy%0d@%0d", m, cyc), 64'(busy[m]), 64'(m_active[m]));
            chk($sformatf("done%0d@%0d", m, cyc), 64'(done[m]), 64'(m_done[m]));
            chk($sformatf("result%0d@%0d", m, cyc), 64'(res[m]), 64'(m_res[m]));
            chk($sformatf("ovf%0d@%0d", m, cyc), 64'(ovf[m]), 64'(m_ovf[m]));
            if (done[m] === 1'b1) begin
                obs_done[m] = cyc;
                obs_ndone[m]++;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        for (int m = 0; m < 2; m++) begin
            obs_done[m]  = -1000;
            obs_ndone[m] = 0;
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int k);
        iA = a;
        iB = b;
        iStart = 1'b1;
        tick();
        k = cyc;
        iStart = 1'b0;
    endtask

    initial begin
        int k;
        for (int m = 0; m < 2; m++) begin
            m_active[m] = 1'b0; m_done[m] = 1'b0; m_ovf[m] = 1'b0;
            m_res[m] = 0; m_prod[m] = 0; m_dcyc[m] = 0;
        end
        clear_obs();
        Reset = 1'b0; iStart = 1'b0; iA = '0; iB = '0;
        ticks(3);
        Reset = 1'b1;
        ticks(40);
        chk("idle_no_done", 64'(obs_ndone[0] + obs_ndone[1]), 64'(0));

        // 465 x 70: done after 16 edges (EE=0) and 7 edges (EE=1)
        clear_obs();
        start_op(16'd465, 16'd70, k);
        ticks(20);
        chk("lat_465_ee0", 64'(obs_done[0] - k), 64'(16));
        chk("lat_465_ee1", 64'(obs_done[1] - k), 64'(7));
        chk("res_465_ee0", 64'(res[0]), 64'h7F26);
        chk("res_465_ee1", 64'(res[1]), 64'h7F26);

        clear_obs();
        start_op(16'd465, 16'd0, k);
        ticks(20);
        chk("lat_b0_ee1", 64'(obs_done[1] - k), 64'(1));
        chk("res_b0_ee1", 64'(res[1]), 64'(0));

        start_op(16'hFFFF, 16'hFFFF, k);
        ticks(20);
        chk("res_max", 64'(res[0]), 64'hFFFE0001);
        chk("ovf_max", 64'(ovf[0]), 64'(1));
        start_op(16'd3, 16'd5, k);
        ticks(20);
        chk("res_3x5", 64'(res[0]), 64'(15));
        chk("ovf_3x5", 64'(ovf[0]), 64'(0));

        // Start held high while busy: EE=0 ignores it; EE=1 picks it up once idle again
        clear_obs();
        start_op(16'd465, 16'd70, k);
        ticks(2);
        iA = 16'd2; iB = 16'd2; iStart = 1'b1;
        ticks(8);
        iStart = 1'b0;
        ticks(15);
        chk("busy_start_ndone0", 64'(obs_ndone[0]), 64'(1));
        chk("busy_start_lat0", 64'(obs_done[0] - k), 64'(16));
        chk("busy_start_res0", 64'(res[0]), 64'(32550));
        chk("busy_start_ndone1", 64'(obs_ndone[1]), 64'(2));
        chk("busy_start_res1", 64'(res[1]), 64'(4));

        // Reset mid-run discards the operation
        clear_obs();
        start_op(16'd465, 16'd70, k);
        ticks(5);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk("rst_busy0", 64'(busy[0]), 64'(0));
        chk("rst_res0", 64'(res[0]), 64'(0));
        ticks(20);
        chk("rst_no_done", 64'(obs_ndone[0] + obs_ndone[1]), 64'(0));
        start_op(16'd7, 16'd9, k);
        ticks(20);
        chk("res_7x9_ee0", 64'(res[0]), 64'(63));
        chk("lat_7x9_ee0", 64'(obs_done[0] - k), 64'(16));
        chk("res_7x9_ee1", 64'(res[1]), 64'(63));
        chk("lat_7x9_ee1", 64'(obs_done[1] - k), 64'(4));

        // Randomized traffic with occasional resets and extreme operands
        for (int i = 0; i < 800; i++) begin
            iStart = ($urandom_range(0, 3) == 0);
            iA = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            iB = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom >> $urandom_range(0, 15));
            Reset = ($urandom_range(0, 63) != 0);
            tick();
        end
        Reset = 1'b1;
        iStart = 1'b0;
        ticks(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
